// File: rtl/pipeline_stall_sequencer_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_sequencer_if
//   Bundles the hazard qualifiers coming from ID/EX and the stall/flush
//   controls going back to the fetch/decode pipeline registers.
//
//   master : hazard source (drives qualifiers, observes controls/counters)
//   slave  : the sequencer itself
//
//   Qualifiers  : ld_use_haz, id_branch, ex_flag_wr, ex_mem_rd, br_taken,
//                 mem_busy
//   Controls    : PCWrite, IFWrite, IDEX_ctrl_flush, IFID_flush
//   Observation : state_o, stall_cnt, flush_cnt, hang_err
// ---------------------------------------------------------------------------
interface pipeline_stall_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             ld_use_haz;
  logic             id_branch;
  logic             ex_flag_wr;
  logic             ex_mem_rd;
  logic             br_taken;
  logic             mem_busy;
  logic             PCWrite;
  logic             IFWrite;
  logic             IDEX_ctrl_flush;
  logic             IFID_flush;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hang_err;

  modport master (
    output ld_use_haz, id_branch, ex_flag_wr, ex_mem_rd, br_taken, mem_busy,
    input  PCWrite, IFWrite, IDEX_ctrl_flush, IFID_flush,
    input  state_o, stall_cnt, flush_cnt, hang_err
  );

  modport slave (
    input  ld_use_haz, id_branch, ex_flag_wr, ex_mem_rd, br_taken, mem_busy,
    output PCWrite, IFWrite, IDEX_ctrl_flush, IFID_flush,
    output state_o, stall_cnt, flush_cnt, hang_err
  );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_stall_sequencer
//   Turns load-use hazards, branch-on-flag hazards, taken-branch redirects
//   and memory-busy freezes into per-cycle PC/IF-ID write enables and
//   flush controls. Also keeps saturating stall/flush counters and a
//   sticky watchdog that flags runs of MAX_STALL consecutive stalled cycles.
//
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of pipeline_stall_sequencer_if (qualifiers in,
//           controls / state / counters / hang_err out)
//
//   Controls are combinational from (state, qualifiers); all state,
//   counters and watchdog update on the rising edge.
// ---------------------------------------------------------------------------
module pipeline_stall_sequencer #(
  parameter int BR_FLUSH_CYCLES = 1,   // 1..7
  parameter int CNT_W           = 16,
  parameter int MAX_STALL       = 8    // 1..255
) (
  input logic                       clk,
  input logic                       reset,
  pipeline_stall_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BRLD    = 2'd1,   // owes the second bubble of a lw -> branch pair
    FLUSH   = 2'd2,   // still squashing wrong-path fetches after a redirect
    ILLEGAL = 2'd3
  } state_e;

  localparam logic [2:0] FL_INIT     = 3'(BR_FLUSH_CYCLES - 1);
  localparam logic [7:0] MAX_STALL_L = 8'(MAX_STALL);

  state_e           state_q, state_d;
  logic [2:0]       fl_ctr_q, fl_ctr_d;
  logic [7:0]       run_len_q, run_len_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             hang_q;

  logic pc_we, if_we, idex_flush, ifid_flush;

  // NOTE: every signal written here gets a default first so no path through
  // the if/case tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = RUN;
    fl_ctr_d   = fl_ctr_q;
    pc_we      = 1'b1;
    if_we      = 1'b1;
    idex_flush = 1'b0;
    ifid_flush = 1'b0;

    if (bus.mem_busy) begin
      // Freeze: sequence position is held, only the stall bookkeeping moves.
      pc_we   = 1'b0;
      if_we   = 1'b0;
      state_d = (state_q == ILLEGAL) ? RUN : state_q;
    end else if (bus.br_taken) begin
      // Redirect overrides any pending bubble.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (BR_FLUSH_CYCLES > 1) begin
        state_d  = FLUSH;
        fl_ctr_d = FL_INIT;
      end else begin
        fl_ctr_d = 3'd0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          ifid_flush = 1'b1;
          // fl_ctr counts the flush cycles still to issue, this one included.
          if (fl_ctr_q > 3'd1) begin
            state_d  = FLUSH;
            fl_ctr_d = fl_ctr_q - 3'd1;
          end else begin
            fl_ctr_d = 3'd0;
          end
        end
        BRLD: begin
          pc_we      = 1'b0;
          if_we      = 1'b0;
          idex_flush = 1'b1;
        end
        default: begin  // RUN, and the unused encoding which recovers to RUN
          if (bus.id_branch && bus.ex_mem_rd) begin
            pc_we      = 1'b0;
            if_we      = 1'b0;
            idex_flush = 1'b1;
            state_d    = (state_q == RUN) ? BRLD : RUN;
          end else if (bus.ld_use_haz || (bus.id_branch && bus.ex_flag_wr)) begin
            pc_we      = 1'b0;
            if_we      = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end

    // Watchdog run length: consecutive stalled cycles, saturating at 255.
    run_len_d = 8'd0;
    if (!pc_we) begin
      run_len_d = (run_len_q == 8'hFF) ? 8'hFF : run_len_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fl_ctr_q    <= 3'd0;
      run_len_q   <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      hang_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fl_ctr_q  <= fl_ctr_d;
      run_len_q <= run_len_d;
      if (run_len_d >= MAX_STALL_L) begin
        hang_q <= 1'b1;
      end
      if (!pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.PCWrite         = pc_we;
  assign bus.IFWrite         = if_we;
  assign bus.IDEX_ctrl_flush = idex_flush;
  assign bus.IFID_flush      = ifid_flush;
  assign bus.state_o         = state_q;
  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.flush_cnt       = flush_cnt_q;
  assign bus.hang_err        = hang_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_sequencer
//   Two sequencer instances share one stimulus stream: dut_a with 16-bit
//   counters and dut_b with 2-bit counters to exercise saturation. Both use
//   BR_FLUSH_CYCLES=3 and MAX_STALL=8. Each driven cycle pushes the expected
//   response into a queue; a separate monitor pops and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_stall_sequencer;

  localparam int BR  = 3;
  localparam int MAX = 8;
  localparam int WA  = 16;
  localparam int WB  = 2;

  logic clk = 1'b0;
  logic reset;
  logic ld_use_haz, id_branch, ex_flag_wr, ex_mem_rd, br_taken, mem_busy;

  always #5 clk = ~clk;

  pipeline_stall_sequencer_if #(.CNT_W(WA)) bus_a ();
  pipeline_stall_sequencer_if #(.CNT_W(WB)) bus_b ();

  assign bus_a.ld_use_haz = ld_use_haz;
  assign bus_a.id_branch  = id_branch;
  assign bus_a.ex_flag_wr = ex_flag_wr;
  assign bus_a.ex_mem_rd  = ex_mem_rd;
  assign bus_a.br_taken   = br_taken;
  assign bus_a.mem_busy   = mem_busy;
  assign bus_b.ld_use_haz = ld_use_haz;
  assign bus_b.id_branch  = id_branch;
  assign bus_b.ex_flag_wr = ex_flag_wr;
  assign bus_b.ex_mem_rd  = ex_mem_rd;
  assign bus_b.br_taken   = br_taken;
  assign bus_b.mem_busy   = mem_busy;

  pipeline_stall_sequencer #(.BR_FLUSH_CYCLES(BR), .CNT_W(WA), .MAX_STALL(MAX))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pipeline_stall_sequencer #(.BR_FLUSH_CYCLES(BR), .CNT_W(WB), .MAX_STALL(MAX))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    logic       pc, ifw, idex, ifid;
    logic [1:0] st;
    int         stalls, flushes;
    logic       hang;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: bubbles still owed and redirect flushes still to issue,
  // plus plain integer tallies.
  int flush_left = 0;
  bit owed       = 0;
  int stalls     = 0;
  int flushes    = 0;
  int run_len    = 0;
  bit hang       = 0;

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict, push.
  task automatic step(input bit r, input bit lu, input bit ib, input bit fw,
                      input bit mr, input bit bt, input bit mb);
    exp_t e;
    int   nfl;
    bit   now;
    @(negedge clk);
    reset      = r;
    ld_use_haz = lu; id_branch = ib; ex_flag_wr = fw;
    ex_mem_rd  = mr; br_taken  = bt; mem_busy   = mb;
    if (r) begin
      flush_left = 0; owed = 0; stalls = 0; flushes = 0; run_len = 0; hang = 0;
    end
    e.st      = owed ? 2'd1 : ((flush_left > 0) ? 2'd2 : 2'd0);
    e.stalls  = stalls;
    e.flushes = flushes;
    e.hang    = hang;
    e.pc = 1'b1; e.ifw = 1'b1; e.idex = 1'b0; e.ifid = 1'b0;
    nfl = flush_left;
    now = owed;
    if (mb) begin
      e.pc = 1'b0; e.ifw = 1'b0;
    end else if (bt) begin
      e.ifid = 1'b1; e.idex = 1'b1;
      nfl = BR - 1; now = 1'b0;
    end else if (flush_left > 0) begin
      e.ifid = 1'b1;
      nfl = flush_left - 1;
    end else if (owed) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.idex = 1'b1;
      now = 1'b0;
    end else if (ib && mr) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.idex = 1'b1;
      now = 1'b1;
    end else if (lu || (ib && fw)) begin
      e.pc = 1'b0; e.ifw = 1'b0; e.idex = 1'b1;
    end
    sb_q.push_back(e);
    if (!r) begin
      flush_left = nfl;
      owed       = now;
      if (!e.pc) begin
        stalls++;
        run_len++;
      end else begin
        run_len = 0;
      end
      if (e.ifid) flushes++;
      if (run_len >= MAX) hang = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUTs present 2 ns after each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("PCWrite",         int'(bus_a.PCWrite),         int'(e.pc));
        check("IFWrite",         int'(bus_a.IFWrite),         int'(e.ifw));
        check("IDEX_ctrl_flush", int'(bus_a.IDEX_ctrl_flush), int'(e.idex));
        check("IFID_flush",      int'(bus_a.IFID_flush),      int'(e.ifid));
        check("state_o",         int'(bus_a.state_o),         int'(e.st));
        check("stall_cnt_a",     int'(bus_a.stall_cnt),       sat(e.stalls, WA));
        check("flush_cnt_a",     int'(bus_a.flush_cnt),       sat(e.flushes, WA));
        check("hang_err_a",      int'(bus_a.hang_err),        int'(e.hang));
        check("PCWrite_b",       int'(bus_b.PCWrite),         int'(e.pc));
        check("stall_cnt_b",     int'(bus_b.stall_cnt),       sat(e.stalls, WB));
        check("flush_cnt_b",     int'(bus_b.flush_cnt),       sat(e.flushes, WB));
        check("hang_err_b",      int'(bus_b.hang_err),        int'(e.hang));
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1;
    ld_use_haz = 0; id_branch = 0; ex_flag_wr = 0;
    ex_mem_rd  = 0; br_taken  = 0; mem_busy   = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Single load-use bubble.
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // lw -> branch: two bubbles, then the flag-writer single bubble.
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(1);
    // Taken branch: three flush cycles.
    step(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // Redirect while owing the second lw->br bubble.
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    idle(3);
    // Memory freeze in the middle of a flush sequence.
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Eight-cycle freeze trips the watchdog, which stays set.
    for (int i = 0; i < MAX; i++) step(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Reset in the middle of a flush sequence.
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        step(1, 0, 0, 0, 0, 0, 0);
      end else begin
        step(0,
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 7) == 0));
      end
    end
    idle(1);

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #5;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
